// File: rtl/pc_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// pc_hazard_ctrl
//
// Sequencing controller for the PC register and the IF/ID and ID/EX pipeline
// registers of a 5-stage MIPS pipeline.  Every cycle it chooses between
// PC+4, the ID-stage redirect target, or holding the PC.  It also raises the
// IF/ID write/flush, ID/EX bubble and whole-pipe hold controls from decoded
// hazards and the instruction/data memory ready handshakes.  It keeps
// saturating stall and redirect statistics.
//
// Control outputs are a combinational decode of the FSM state plus inputs, so
// a stall acts in the same cycle the hazard is seen.
//
// Optional feature: define PC_HAZARD_WDOG_EN to add wdog_err, a sticky flag
// raised after WDOG_LIMIT consecutive cycles spent in IWAIT/DWAIT.
//
// Ports:
//   clk, rst            clock, asynchronous active-low reset
//   id_rs, id_rt        source register fields of the ID instruction
//   id_branch, id_jump  ID instruction is a branch / jump
//   branch_taken        ID branch comparison result
//   ex_memread, ex_regwrite, ex_rd   EX stage load / reg write / destination
//   mem_memread, mem_rd              MEM stage load / destination
//   imem_ready          instruction fetch for current PC complete
//   mem_req, dmem_ready MEM stage data access and its completion
//   pc_write, pc_sel    PC enable; 1 = PC+4, 0 = redirect target
//   ifid_write, ifid_flush, idex_bubble, pipe_hold   pipeline controls
//   imem_abort          one-cycle cancel of the outstanding fetch
//   stall_cycles        saturating count of cycles with pc_write=0
//   redirect_cnt        saturating count of redirects taken
//   wdog_err            (PC_HAZARD_WDOG_EN only) sticky wait watchdog
// ---------------------------------------------------------------------------
module pc_hazard_ctrl #(
  parameter int CNT_W      = 16,
  parameter int WDOG_LIMIT = 255
) (
  input  logic             rst,
  input  logic             clk,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_branch,
  input  logic             id_jump,
  input  logic             branch_taken,
  input  logic             ex_memread,
  input  logic             ex_regwrite,
  input  logic [4:0]       ex_rd,
  input  logic             mem_memread,
  input  logic [4:0]       mem_rd,
  input  logic             imem_ready,
  input  logic             mem_req,
  input  logic             dmem_ready,
  output logic             pc_write,
  output logic             pc_sel,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic             pipe_hold,
  output logic             imem_abort,
`ifdef PC_HAZARD_WDOG_EN
  output logic             wdog_err,
`endif
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] redirect_cnt
);

  typedef enum logic [1:0] {RUN, IWAIT, DWAIT} state_t;

  state_t state, state_nx;
  logic   lu, bh, redir, redir_go;
  logic   ex_match, mem_match;

  // Register 0 is hardwired, so a destination of 0 never creates a hazard.
  assign ex_match  = (ex_rd != 5'd0) && ((ex_rd == id_rs) || (ex_rd == id_rt));
  assign mem_match = (mem_rd != 5'd0) && ((mem_rd == id_rs) || (mem_rd == id_rt));

  assign lu = ex_memread && ex_match;

  // A branch compares in ID, so it needs its operands from EX (any writer)
  // and from MEM when that is a load still in flight.
  assign bh = id_branch && ((ex_regwrite && ex_match) || (mem_memread && mem_match));

  // A redirect whose branch operands are not yet available must wait.
  assign redir = (id_jump || (id_branch && branch_taken)) && !bh;

  always_comb begin
    pc_write    = 1'b1;
    pc_sel      = 1'b1;
    ifid_write  = 1'b1;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    pipe_hold   = 1'b0;
    imem_abort  = 1'b0;
    redir_go    = 1'b0;
    state_nx    = state;
    if (!rst) begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      state_nx   = RUN;
    end else if ((state == DWAIT || mem_req) && !dmem_ready) begin
      // Data miss freezes everything; no redirect is acted on meanwhile.
      pipe_hold  = 1'b1;
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      state_nx   = DWAIT;
    end else if (lu || bh) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_bubble = 1'b1;
      state_nx    = (state == IWAIT && !imem_ready) ? IWAIT : RUN;
    end else if (redir) begin
      // A fetch still outstanding for the wrong path must be cancelled.
      pc_sel     = 1'b0;
      ifid_flush = 1'b1;
      imem_abort = !imem_ready || (state == IWAIT);
      redir_go   = 1'b1;
      state_nx   = RUN;
    end else if (!imem_ready) begin
      pc_write   = 1'b0;
      ifid_flush = 1'b1;
      state_nx   = IWAIT;
    end else begin
      state_nx = RUN;
    end
  end

  // FSM and saturating statistics.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= RUN;
      stall_cycles <= '0;
      redirect_cnt <= '0;
    end else begin
      state <= state_nx;
      if (!pc_write && stall_cycles != '1)
        stall_cycles <= stall_cycles + CNT_W'(1);
      if (redir_go && redirect_cnt != '1)
        redirect_cnt <= redirect_cnt + CNT_W'(1);
    end
  end

`ifdef PC_HAZARD_WDOG_EN
  localparam int WD_W = $clog2(WDOG_LIMIT + 1);

  logic [WD_W-1:0] wd_cnt;

  // Counts consecutive wait-state cycles; the error is sticky until reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wd_cnt   <= '0;
      wdog_err <= 1'b0;
    end else if (state == RUN) begin
      wd_cnt <= '0;
    end else begin
      if (wd_cnt != WD_W'(WDOG_LIMIT))
        wd_cnt <= wd_cnt + WD_W'(1);
      if (wd_cnt == WD_W'(WDOG_LIMIT - 1))
        wdog_err <= 1'b1;
    end
  end
`else
  // Keeps the limit parameter referenced when the watchdog is compiled out.
  logic unused_wdog_limit;
  assign unused_wdog_limit = (WDOG_LIMIT != 0);
`endif

endmodule

// File: tb/tb_pc_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pc_hazard_ctrl
//
// Self-checking bench for pc_hazard_ctrl.  Directed vectors are driven one
// per cycle; each vector pushes its hand-computed expected response into a
// scoreboard queue, and a monitor on the falling edge pops and compares.
// Counters are instantiated at 4 bits so saturation is reachable.
// With PC_HAZARD_WDOG_EN defined the watchdog is also exercised (limit 4).
// ---------------------------------------------------------------------------
module tb_pc_hazard_ctrl;

  localparam int CNT_W = 4;

  logic             clk;
  logic             rst;
  logic [4:0]       id_rs, id_rt, ex_rd, mem_rd;
  logic             id_branch, id_jump, branch_taken;
  logic             ex_memread, ex_regwrite, mem_memread;
  logic             imem_ready, mem_req, dmem_ready;
  logic             pc_write, pc_sel, ifid_write, ifid_flush;
  logic             idex_bubble, pipe_hold, imem_abort;
  logic [CNT_W-1:0] stall_cycles, redirect_cnt;
`ifdef PC_HAZARD_WDOG_EN
  logic             wdog_err;
`endif

  typedef struct {
    string      name;
    logic [6:0] ctrl;
    int         stall;
    int         redir;
    bit         chk_wd;
    logic       wd;
  } exp_t;

  exp_t sb[$];
  int   tests_run = 0;
  int   tests_failed = 0;

  pc_hazard_ctrl #(.CNT_W(CNT_W), .WDOG_LIMIT(4)) dut (
    .rst          (rst),
    .clk          (clk),
    .id_rs        (id_rs),
    .id_rt        (id_rt),
    .id_branch    (id_branch),
    .id_jump      (id_jump),
    .branch_taken (branch_taken),
    .ex_memread   (ex_memread),
    .ex_regwrite  (ex_regwrite),
    .ex_rd        (ex_rd),
    .mem_memread  (mem_memread),
    .mem_rd       (mem_rd),
    .imem_ready   (imem_ready),
    .mem_req      (mem_req),
    .dmem_ready   (dmem_ready),
    .pc_write     (pc_write),
    .pc_sel       (pc_sel),
    .ifid_write   (ifid_write),
    .ifid_flush   (ifid_flush),
    .idex_bubble  (idex_bubble),
    .pipe_hold    (pipe_hold),
    .imem_abort   (imem_abort),
`ifdef PC_HAZARD_WDOG_EN
    .wdog_err     (wdog_err),
`endif
    .stall_cycles (stall_cycles),
    .redirect_cnt (redirect_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard time limit so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL timeout: simulation did not finish, got running required finished");
    $fatal(1, "[TB] timeout");
  end

  task automatic check_output(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h required %0h", nm, act, exp);
    end
  endtask

  task automatic set_idle();
    id_rs        = 5'd1;
    id_rt        = 5'd2;
    id_branch    = 1'b0;
    id_jump      = 1'b0;
    branch_taken = 1'b0;
    ex_memread   = 1'b0;
    ex_regwrite  = 1'b0;
    ex_rd        = 5'd0;
    mem_memread  = 1'b0;
    mem_rd       = 5'd0;
    imem_ready   = 1'b1;
    mem_req      = 1'b0;
    dmem_ready   = 1'b1;
  endtask

  // ctrl order: pc_write, pc_sel, ifid_write, ifid_flush, idex_bubble,
  // pipe_hold, imem_abort.  Counter values are those visible during the cycle.
  task automatic apply_stimulus(input string nm, input logic [6:0] ctrl,
                                input int stall, input int redir,
                                input bit chk_wd = 1'b0, input logic wd = 1'b0);
    exp_t e;
    e.name   = nm;
    e.ctrl   = ctrl;
    e.stall  = stall;
    e.redir  = redir;
    e.chk_wd = chk_wd;
    e.wd     = wd;
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  // Monitor: the control block presents a response every cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check_output({e.name, ".ctrl"},
                     {25'd0, pc_write, pc_sel, ifid_write, ifid_flush,
                      idex_bubble, pipe_hold, imem_abort}, {25'd0, e.ctrl});
        check_output({e.name, ".stall_cycles"}, {28'd0, stall_cycles}, e.stall);
        check_output({e.name, ".redirect_cnt"}, {28'd0, redirect_cnt}, e.redir);
`ifdef PC_HAZARD_WDOG_EN
        if (e.chk_wd)
          check_output({e.name, ".wdog_err"}, {31'd0, wdog_err}, {31'd0, e.wd});
`endif
      end
    end
  end

  initial begin
    rst = 1'b0;
    set_idle();
    @(posedge clk);
    #1;

    // Reset held, then release into idle running.
    for (int i = 0; i < 3; i++) apply_stimulus("reset", 7'b0100000, 0, 0);
    rst = 1'b1;
    apply_stimulus("idle0", 7'b1110000, 0, 0);
    apply_stimulus("idle1", 7'b1110000, 0, 0);

    // Load-use stall, then the register-0 case that must not stall.
    ex_memread = 1'b1; ex_rd = 5'd8; id_rs = 5'd8;
    apply_stimulus("load_use", 7'b0100100, 0, 0);
    set_idle();
    apply_stimulus("lu_after", 7'b1110000, 1, 0);
    ex_memread = 1'b1; ex_rd = 5'd0; id_rs = 5'd0; id_rt = 5'd0;
    apply_stimulus("lu_r0", 7'b1110000, 1, 0);

    // Taken branch behind a load: two stall cycles then redirect.
    set_idle();
    id_branch = 1'b1; branch_taken = 1'b1; id_rs = 5'd9;
    ex_memread = 1'b1; ex_regwrite = 1'b1; ex_rd = 5'd9;
    apply_stimulus("bl_c1", 7'b0100100, 1, 0);
    ex_memread = 1'b0; ex_regwrite = 1'b0; ex_rd = 5'd0;
    mem_memread = 1'b1; mem_rd = 5'd9;
    apply_stimulus("bl_c2", 7'b0100100, 2, 0);
    mem_memread = 1'b0; mem_rd = 5'd0;
    apply_stimulus("bl_c3", 7'b1011000, 3, 0);
    set_idle();
    apply_stimulus("bl_after", 7'b1110000, 3, 1);

    // Branch on an ALU result in EX, and a not-taken branch.
    id_branch = 1'b1; ex_regwrite = 1'b1; ex_rd = 5'd5; id_rt = 5'd5;
    apply_stimulus("bh_alu", 7'b0100100, 3, 1);
    set_idle();
    id_branch = 1'b1;
    apply_stimulus("nt_branch", 7'b1110000, 4, 1);

    // Jump while the fetch is outstanding aborts it.
    set_idle();
    id_jump = 1'b1; imem_ready = 1'b0;
    apply_stimulus("jump_abort", 7'b1011001, 4, 1);

    // I-miss for 4 cycles with a jump on the third.
    set_idle();
    imem_ready = 1'b0;
    apply_stimulus("im_c1", 7'b0111000, 4, 2);
    apply_stimulus("im_c2", 7'b0111000, 5, 2);
    id_jump = 1'b1;
    apply_stimulus("im_c3", 7'b1011001, 6, 2);
    id_jump = 1'b0;
    apply_stimulus("im_c4", 7'b0111000, 6, 3);
    imem_ready = 1'b1;
    apply_stimulus("im_c5", 7'b1110000, 7, 3);

    // D-miss for 5 cycles with a jump held; redirect only on completion.
    set_idle();
    mem_req = 1'b1; dmem_ready = 1'b0; id_jump = 1'b1;
    for (int i = 0; i < 5; i++) apply_stimulus("dm_wait", 7'b0100010, 7 + i, 3);
    dmem_ready = 1'b1;
    apply_stimulus("dm_done", 7'b1011000, 12, 3);
    set_idle();
    apply_stimulus("dm_after", 7'b1110000, 12, 4);

    // D-miss arriving during an I-miss; fetch re-checked afterwards.
    imem_ready = 1'b0;
    apply_stimulus("iw_c1", 7'b0111000, 12, 4);
    mem_req = 1'b1; dmem_ready = 1'b0;
    apply_stimulus("iw_dmiss", 7'b0100010, 13, 4);
    dmem_ready = 1'b1;
    apply_stimulus("iw_dready", 7'b0111000, 14, 4);
    set_idle();
    apply_stimulus("iw_done", 7'b1110000, 15, 4);

    // Stall counter saturates at 15 for a 4-bit counter.
    mem_req = 1'b1; dmem_ready = 1'b0;
    apply_stimulus("sat_d1", 7'b0100010, 15, 4);
    apply_stimulus("sat_d2", 7'b0100010, 15, 4);

    // Reset in the middle of a wait returns to RUN.
    rst = 1'b0;
    apply_stimulus("rst_mid", 7'b0100000, 0, 0);
    rst = 1'b1; mem_req = 1'b0; dmem_ready = 1'b0;
    apply_stimulus("rst_rel", 7'b1110000, 0, 0, 1'b1, 1'b0);
    set_idle();
    apply_stimulus("rst_idle", 7'b1110000, 0, 0, 1'b1, 1'b0);

`ifdef PC_HAZARD_WDOG_EN
    // Six cycles of data wait: error after the fourth cycle in DWAIT.
    mem_req = 1'b1; dmem_ready = 1'b0;
    apply_stimulus("wd_1", 7'b0100010, 0, 0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) apply_stimulus("wd_wait", 7'b0100010, 1 + i, 0, 1'b1, 1'b0);
    apply_stimulus("wd_6", 7'b0100010, 5, 0, 1'b1, 1'b1);
    mem_req = 1'b0; dmem_ready = 1'b1;
    apply_stimulus("wd_rel", 7'b1110000, 6, 0, 1'b1, 1'b1);
    apply_stimulus("wd_run", 7'b1110000, 6, 0, 1'b1, 1'b1);
    rst = 1'b0;
    apply_stimulus("wd_rst", 7'b0100000, 0, 0, 1'b1, 1'b0);
    rst = 1'b1;
`endif

    @(negedge clk);
    check_output("sb_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/pc_hazard_ctrl.md
Name: pc_hazard_ctrl

Overview:
- Sequencing controller for the program-counter register and IF/ID/ID-EX pipeline registers of the 5-stage MIPS pipeline.
- Each cycle decides: PC increments, PC takes the ID-stage redirect target, or PC holds.
- Also generates the IF/ID write/flush, ID/EX bubble and whole-pipe hold, from decoded hazards and the instruction/data memory ready handshakes.
- Keeps saturating stall statistics.

Parameters:
- CNT_W, 16, width of the stall_cycles and redirect_cnt counters.
- WDOG_LIMIT, 255, maximum consecutive wait-state cycles before wdog_err; used only with the optional feature.

Ports:
- rst  in  1  asynchronous, active-low reset
- clk  in  1  clock
- id_rs  in  5  rs field of the instruction in ID
- id_rt  in  5  rt field of the instruction in ID
- id_branch  in  1  ID instruction is beq/bne
- id_jump  in  1  ID instruction is j/jal/jr
- branch_taken  in  1  branch comparison result in ID; valid when id_branch=1
- ex_memread  in  1  EX instruction is a load
- ex_regwrite  in  1  EX instruction writes a register
- ex_rd  in  5  EX destination register
- mem_memread  in  1  MEM instruction is a load
- mem_rd  in  5  MEM destination register
- imem_ready  in  1  instruction fetch for the current PC is complete
- mem_req  in  1  MEM stage is accessing data memory
- dmem_ready  in  1  data memory access completes this cycle
- pc_write  out  1  PC register write enable
- pc_sel  out  1  1 = PC+4, 0 = ID redirect target
- ifid_write  out  1  IF/ID register write enable
- ifid_flush  out  1  load a NOP into IF/ID
- idex_bubble  out  1  load control zeros into ID/EX
- pipe_hold  out  1  hold ID/EX, EX/MEM and MEM/WB
- imem_abort  out  1  one-cycle pulse to cancel the outstanding fetch
- stall_cycles  out  CNT_W  saturating count of cycles with pc_write=0
- redirect_cnt  out  CNT_W  saturating count of redirects taken

Behaviour:
- Registered state: FSM, counters, watchdog. Control outputs are combinational decode of state plus inputs, so stalls act in the same cycle.
- Reset (rst=0, asynchronous): FSM=RUN, stall_cycles=0, redirect_cnt=0, wdog_err=0.
- Outputs with rst=0: pc_write=0, pc_sel=1, ifid_write=0, ifid_flush=0, idex_bubble=0, pipe_hold=0, imem_abort=0.
- A reset mid-wait discards the wait and returns to RUN.
- Default (no condition active): pc_write=1, pc_sel=1, ifid_write=1, other controls 0.
- Hazard terms (register 0 never matches):
  - LU = ex_memread & ex_rd!=0 & (ex_rd==id_rs | ex_rd==id_rt).
  - BH = id_branch & [(ex_regwrite & ex_rd!=0 & ex_rd matches rs/rt) | (mem_memread & mem_rd!=0 & mem_rd matches rs/rt)].
  - REDIR = id_jump | (id_branch & branch_taken). REDIR is qualified by ~BH.
- FSM states: RUN, IWAIT, DWAIT.
- RUN, priority high to low:
  1. mem_req & ~dmem_ready: pipe_hold=1, pc_write=0, ifid_write=0. Next state DWAIT.
  2. LU or BH: pc_write=0, ifid_write=0, idex_bubble=1. Stay in RUN; re-evaluate next cycle. A branch behind a load therefore stalls 2 cycles.
  3. REDIR: pc_write=1, pc_sel=0, ifid_flush=1. imem_abort=1 if imem_ready=0. redirect_cnt+1. Stay in RUN.
  4. ~imem_ready: pc_write=0, ifid_write=1, ifid_flush=1. Next state IWAIT.
  5. Otherwise default.
- IWAIT:
  - Same priority as RUN.
  - Item 1 moves to DWAIT; the fetch stays outstanding and imem_ready is re-checked after DWAIT.
  - Item 3 fires imem_abort=1 and returns to RUN.
  - imem_ready=1 with no higher item gives default outputs; next state RUN.
- DWAIT:
  - pipe_hold=1, pc_write=0, ifid_write=0; no redirect is acted on.
  - In the cycle dmem_ready=1, pipe_hold=0 and RUN decoding applies; next state is then determined per RUN.
- Counters saturate at all-ones and never wrap.
- stall_cycles increments every cycle pc_write=0 while rst=1.

Optional Feature:
- Macro: PC_HAZARD_WDOG_EN.
- When defined:
  - Adds output wdog_err (1 bit).
  - A counter of consecutive cycles in IWAIT or DWAIT clears on entry to RUN.
  - When the counter reaches WDOG_LIMIT, wdog_err sets and stays set until reset.
  - Control outputs are unaffected.
- When undefined: no port, no counter logic.

Test Plan:
- Reset: rst=0 for 3 cycles, then release with imem_ready=1 and no hazards -> all outputs at reset values, then pc_write=1, pc_sel=1 every cycle, stall_cycles=0.
- Load-use: ex_memread=1, ex_rd=8, id_rs=8 for 1 cycle -> pc_write=0, ifid_write=0, idex_bubble=1 that cycle; stall_cycles=1.
  - Same with ex_rd=0 -> no stall.
- Branch behind load: id_branch=1, branch_taken=1, id_rs=9. Cycle 1 ex_memread=1, ex_rd=9; cycle 2 mem_memread=1, mem_rd=9; cycle 3 clear.
  - Required: 2 stall cycles, then pc_sel=0, pc_write=1, ifid_flush=1; redirect_cnt=1.
- I-miss then jump: imem_ready=0 for 4 cycles, id_jump=1 on the 3rd.
  - Cycle 1: enter IWAIT, ifid_flush=1, pc_write=0.
  - Cycle 3: pc_sel=0, imem_abort=1, FSM returns to RUN.
- D-miss: mem_req=1, dmem_ready=0 for 5 cycles with REDIR=1 held.
  - pipe_hold=1 and pc_write=0 for those cycles.
  - Redirect is taken only in the cycle dmem_ready=1.
- Watchdog (PC_HAZARD_WDOG_EN, WDOG_LIMIT=4): dmem_ready=0 for 6 cycles -> wdog_err=1 after the 4th wait cycle, still 1 after dmem_ready=1, cleared only by rst=0.
